// File: rtl/cpu_v1_pkg.sv
// Shared CPUv1 constants and the register-dump state encoding.
package cpu_v1_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    FIN  = 2'd3
  } dump_state_e;

endpackage

// File: rtl/reg_dump_if.sv
// Valid/ready beat stream carrying one dumped register per transfer.
interface reg_dump_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) ();

  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_data;
  logic [REG_AW-1:0] out_idx;
  logic              out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_idx,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_idx,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/reg_file.sv
// CPUv1 register storage with one write port and one combinational read port.
// x0 is stored like any other entry; readers are responsible for forcing it to zero.
module reg_file #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [XLEN-1:0]   wdata,
  input  logic [REG_AW-1:0] raddr,
  output logic [XLEN-1:0]   rdata
);

  localparam int unsigned NREG = 1 << REG_AW;

  logic [XLEN-1:0] mem_q [NREG];
  logic [XLEN-1:0] mem_d [NREG];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/reg_dump.sv
// Walks a register index range through a spare register-file read port and
// streams each value as a tagged valid/ready beat.
module reg_dump
  import cpu_v1_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [REG_AW-1:0] first_idx,
  input  logic [REG_AW-1:0] last_idx,
  output logic [REG_AW-1:0] rf_raddr,
  input  logic [XLEN-1:0]   rf_rdata,
  reg_dump_if.master        out,
  output logic              busy,
  output logic              done
);

  dump_state_e       state_q, state_d;
  logic [REG_AW-1:0] ptr_q, ptr_d;
  logic [REG_AW-1:0] end_q, end_d;
  logic [XLEN-1:0]   data_q, data_d;
  logic [REG_AW-1:0] idx_q, idx_d;
  logic              last_q, last_d;
  logic              valid_q, valid_d;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    end_d   = end_q;
    data_d  = data_q;
    idx_d   = idx_q;
    last_d  = last_q;
    valid_d = valid_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (first_idx <= last_idx) begin
            ptr_d   = first_idx;
            end_d   = last_idx;
            state_d = READ;
          end else begin
            state_d = FIN;
          end
        end
      end
      READ: begin
        // x0 reads as zero regardless of what the port returns
        data_d  = (ptr_q == REG_AW'(REG_ZERO)) ? '0 : rf_rdata;
        idx_d   = ptr_q;
        last_d  = (ptr_q == end_q);
        valid_d = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        if (out.out_ready) begin
          valid_d = 1'b0;
          if (last_q) begin
            state_d = FIN;
          end else begin
            ptr_d   = ptr_q + 1'b1;
            state_d = READ;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      end_q   <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      end_q   <= end_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  assign rf_raddr      = ptr_q;
  assign out.out_valid = valid_q;
  assign out.out_data  = data_q;
  assign out.out_idx   = idx_q;
  assign out.out_last  = last_q;
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == FIN);

endmodule

// File: doc/reg_dump.md
Name: reg_dump

Overview:
- Debug reader for the CPUv1 register file. It replaces ad-hoc simulation printing with a synthesizable readout.
- On a start pulse it walks a register index range through a spare register-file read port. It streams each value out over a valid/ready interface tagged with the index and a last flag.
- It sits beside reg_file and drives one read address. It feeds a debug UART or a trace sink.

Parameters:
- XLEN, 32, register data width.
- REG_AW, 5, register index width (32 registers).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle dump request; sampled only in IDLE.
- first_idx  input  REG_AW  first register to dump; captured on accepted start.
- last_idx  input  REG_AW  last register to dump, inclusive; captured on accepted start.
- rf_raddr  output  REG_AW  read address to the register-file port.
- rf_rdata  input  XLEN  combinational read data for rf_raddr.
- out_valid  output  1  beat available.
- out_ready  input  1  sink accepts beat.
- out_data  output  XLEN  register value.
- out_idx  output  REG_AW  register index of the beat.
- out_last  output  1  final beat of the dump.
- busy  output  1  dump in progress (state != IDLE).
- done  output  1  one-cycle pulse when the dump completes.

Behaviour:
- Reset: async assertion of rst_n forces the following, regardless of the state at the time, including mid-dump:
  - state=IDLE, ptr=0, end=0, rf_raddr=0.
  - out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0, done=0.
  - An in-flight beat is dropped; no beat is emitted after release until a new start.
- rf_raddr equals ptr in every state (registered, glitch-free).
- FSM states: IDLE, READ, SEND, FIN.
- IDLE:
  - start=1 and first_idx<=last_idx: ptr<=first_idx, end<=last_idx, go READ.
  - start=1 and first_idx>last_idx: go FIN; no beats are emitted.
  - start=0: stay.
- READ (one cycle), registered on the clock edge ending the cycle:
  - out_data<=(ptr==0 ? 0 : rf_rdata); x0 is always reported as 0 whatever the port returns.
  - out_idx<=ptr, out_last<=(ptr==end), out_valid<=1, go SEND.
- SEND:
  - Hold out_valid and all out_* stable until out_valid&&out_ready.
  - On handshake, out_valid<=0. If out_last, go FIN; else ptr<=ptr+1, go READ.
- FIN (one cycle): done=1, go IDLE. busy is still 1 in FIN.
- Latency: first out_valid appears 2 cycles after the accepted start edge. Peak throughput is 1 beat per 2 cycles with out_ready held high.
- Start while busy is ignored; it is not queued.
- ptr wrap-around is impossible: the dump ends at ptr==end<=31, so it never increments past 31.
- The value is sampled in the READ cycle. A register-file write to the same index in that cycle is not visible; the pre-write value is read. Later writes to already-dumped registers are not reported.
- out_valid never drops without a handshake. out_* never change while out_valid=1 and out_ready=0.

Decomposition:
- Shared package cpu_v1_pkg:
  - XLEN and REG_AW constants.
  - reg_dump state enum (IDLE/READ/SEND/FIN).
  - REG_ZERO index constant (0).
- Single flat module; no sub-module is needed.
- The bench instantiates reg_file plus reg_dump, with reg_dump on a spare read port.

Test Plan:
- Preload x1=0x11111111, x2=0x22222222, x31=0xDEADBEEF; start with first=0, last=31, out_ready=1:
  - Required: 32 beats with idx 0..31; idx0 data=0, idx1=0x11111111, idx2=0x22222222, idx31=0xDEADBEEF.
  - out_last only on idx31; done pulses exactly once; first out_valid arrives 2 cycles after start.
- Range first=5, last=5 with x5=0xCAFEF00D:
  - Required: exactly one beat, idx=5, data=0xCAFEF00D, out_last=1; done follows the handshake by 1 cycle.
- Range first=10, last=3:
  - Required: no out_valid; done pulses 1 cycle after start; busy high for exactly that FIN cycle.
- Backpressure, first=1, last=3, out_ready toggling 0,0,1 per beat:
  - Required: out_data/out_idx stable while stalled; beats idx 1,2,3 in order, none lost or duplicated.
- Second start pulse mid-dump:
  - Required: ignored; beat count unchanged.
- Assert rst_n=0 while in SEND at idx 7:
  - Required: out_valid=0 and busy=0 immediately (async).
  - After release, no beats without a new start; a new start 0..1 dumps normally.
